alu32_op_sequencer: RTL and testbench
=====================================

Name: alu32_op_sequencer

Overview:
Sequential front/back stage that wraps the combinational 32-bit add/sub ALU. It accepts one operation request over a valid/ready handshake and registers the operands onto the ALU inputs. After a programmable settle window it samples the ALU result and flags. It then presents them downstream over a second valid/ready handshake. This lets the combinational ALU sit in a clocked datapath with a guaranteed timing budget.

Parameters:
WIDTH, 32, operand/result width in bits.
SETTLE_CYCLES, 1, clock edges between operand launch and result capture. A value of 0 is treated as 1.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset; asynchronous, active-low.
req_valid  in  1  request present.
req_ready  out  1  sequencer can accept a request.
req_sub_add  in  1  0 = add, 1 = subtract.
req_a  in  WIDTH  operand A, two's complement.
req_b  in  WIDTH  operand B, two's complement.
alu_sub_add  out  1  registered op select to the ALU.
alu_a  out  WIDTH  registered operand A to the ALU.
alu_b  out  WIDTH  registered operand B to the ALU.
alu_result  in  WIDTH  ALU result.
alu_carry  in  1  ALU carry flag.
alu_zero  in  1  ALU zero flag.
alu_overflow  in  1  ALU overflow flag.
rsp_valid  out  1  response present.
rsp_ready  in  1  downstream accepts the response.
rsp_result  out  WIDTH  captured result.
rsp_carry  out  1  captured carry.
rsp_zero  out  1  captured zero.
rsp_overflow  out  1  captured overflow.
sticky_clr  in  1  clear the sticky flags (feature only).
sticky_carry  out  1  accumulated carry (feature only).
sticky_overflow  out  1  accumulated overflow (feature only).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, settle counter = 0.
  - All alu_* and rsp_* outputs = 0, rsp_valid = 0, sticky flags = 0.
  - req_ready = 0 while rst_n is low.
  - Any in-flight operation is discarded; no response is ever produced for it.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - req_ready = 1.
  - On a clock edge with req_valid=1: latch req_sub_add/req_a/req_b into alu_sub_add/alu_a/alu_b, load counter = max(SETTLE_CYCLES,1), go to SETTLE.
- SETTLE:
  - req_ready = 0.
  - Each edge decrements the counter.
  - On the edge where counter==1: capture alu_result/alu_carry/alu_zero/alu_overflow into the rsp_* registers, set rsp_valid=1, go to RESP.
  - Capture therefore occurs exactly SETTLE_CYCLES edges after the accepting edge.
- RESP:
  - req_ready = 0; rsp_* held stable.
  - On an edge with rsp_ready=1: rsp_valid=0, go to IDLE.
  - rsp_ready=0 stalls indefinitely with no data change.
- alu_* outputs hold their last launched values until the next accept; they do not change in SETTLE, RESP or IDLE.
- rsp_* data keeps its last captured value after the handshake; only rsp_valid drops.
- req_valid is ignored outside IDLE; the request is not lost, because req_ready=0 tells upstream to hold it.
- The flags are passed through unmodified; the sequencer does no arithmetic.
- Throughput: one operation per SETTLE_CYCLES+2 cycles when rsp_ready is held at 1.
- Counter width is clog2(SETTLE_CYCLES+1), minimum 1 bit.

Optional Feature:
Macro ALU32_STICKY_FLAGS_EN.
- Defined:
  - sticky_carry and sticky_overflow are set on any capture edge where the captured flag = 1.
  - sticky_clr=1 clears both synchronously.
  - If clear and set happen on the same edge, set wins.
- Not defined: sticky ports still exist, sticky_* outputs are tied to 0, and sticky_clr is ignored.

Test Plan:
1. Hold rst_n=0 for 3 cycles with req_valid=1 -> all outputs 0, req_ready=0, no capture. Release -> req_ready=1 on the next cycle.
2. SETTLE_CYCLES=1, ALU model attached; request add a=0x00000005, b=0x00000003 -> alu_a=5, alu_b=3, alu_sub_add=0 after the accept edge. One edge later rsp_valid=1, rsp_result=0x00000008, all flags 0. rsp_ready=1 -> IDLE next edge.
3. Request sub a=b=0x12345678 -> rsp_result=0x00000000, rsp_zero=1, rsp_overflow=0.
4. Request add a=0x7FFFFFFF, b=0x00000001 with rsp_ready=0 for 5 cycles and a second request pending -> rsp_overflow=1 and rsp_result=0x80000000 stay stable, req_ready=0 throughout. The second request is accepted only after the response handshake. With the feature: sticky_overflow=1 until sticky_clr is pulsed.
5. SETTLE_CYCLES=4; the ALU model changes alu_result from 0xAAAAAAAA to 0x55555555 two edges after accept -> rsp_result=0x55555555, captured exactly 4 edges after accept.
6. SETTLE_CYCLES=4; assert rst_n=0 two edges after accept -> rsp_valid never rises, state IDLE after release, alu_a=0.

Source files
------------

// File: rtl/alu32_op_sequencer.sv
// alu32_op_sequencer
// Clocked wrapper around a combinational add/sub ALU. It accepts one request
// over a valid/ready handshake and launches the registered operands onto the
// ALU. It waits a fixed settle window, then captures the result and flags and
// offers them downstream over a second valid/ready handshake.
//
// Optional build macro: ALU32_STICKY_FLAGS_EN
//   defined     -> sticky_carry / sticky_overflow accumulate captured flags,
//                  sticky_clr clears them (a set on the same edge wins)
//   not defined -> sticky outputs tied to 0, sticky_clr ignored
module alu32_op_sequencer #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    // request side
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_sub_add,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    // ALU side
    output logic             alu_sub_add,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    // response side
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    // sticky flags
    input  logic             sticky_clr,
    output logic             sticky_carry,
    output logic             sticky_overflow
);

    // A settle window of 0 would capture on the launch edge itself; clamp to 1.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CNT_W_RAW  = $clog2(SETTLE_CYCLES + 1);
    localparam int CNT_W      = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RESP
    } state_t;

    state_t             state_q,        state_d;
    logic [CNT_W-1:0]   cnt_q,          cnt_d;
    logic               alu_sub_add_q,  alu_sub_add_d;
    logic [WIDTH-1:0]   alu_a_q,        alu_a_d;
    logic [WIDTH-1:0]   alu_b_q,        alu_b_d;
    logic               rsp_valid_q,    rsp_valid_d;
    logic [WIDTH-1:0]   rsp_result_q,   rsp_result_d;
    logic               rsp_carry_q,    rsp_carry_d;
    logic               rsp_zero_q,     rsp_zero_d;
    logic               rsp_overflow_q, rsp_overflow_d;
    logic               capture;

    // Next-state, operand launch and result capture.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d        = state_q;
        cnt_d          = cnt_q;
        alu_sub_add_d  = alu_sub_add_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_result_d   = rsp_result_q;
        rsp_carry_d    = rsp_carry_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_overflow_d = rsp_overflow_q;
        capture        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    alu_sub_add_d = req_sub_add;
                    alu_a_d       = req_a;
                    alu_b_d       = req_b;
                    cnt_d         = CNT_LOAD;
                    state_d       = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    capture     = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                // Data stays put; only the valid flag drops on the handshake.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture) begin
            rsp_result_d   = alu_result;
            rsp_carry_d    = alu_carry;
            rsp_zero_d     = alu_zero;
            rsp_overflow_d = alu_overflow;
        end
    end

    // State, counter, launched operands and captured response.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset too, because their reset
        // value is visible on the outputs and must read as zero.
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            alu_sub_add_q  <= 1'b0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_carry_q    <= 1'b0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its neighbours, independent of statement order.
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            alu_sub_add_q  <= alu_sub_add_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_carry_q    <= rsp_carry_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_overflow_q <= rsp_overflow_d;
        end
    end

`ifdef ALU32_STICKY_FLAGS_EN
    logic sticky_carry_q,    sticky_carry_d;
    logic sticky_overflow_q, sticky_overflow_d;

    // Sticky flags: clear first, then a capture with the flag set wins.
    always_comb begin
        sticky_carry_d    = sticky_clr ? 1'b0 : sticky_carry_q;
        sticky_overflow_d = sticky_clr ? 1'b0 : sticky_overflow_q;
        if (capture && alu_carry) begin
            sticky_carry_d = 1'b1;
        end
        if (capture && alu_overflow) begin
            sticky_overflow_d = 1'b1;
        end
    end

    // Sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_carry_q    <= 1'b0;
            sticky_overflow_q <= 1'b0;
        end else begin
            sticky_carry_q    <= sticky_carry_d;
            sticky_overflow_q <= sticky_overflow_d;
        end
    end

    assign sticky_carry    = sticky_carry_q;
    assign sticky_overflow = sticky_overflow_q;
`else
    // Feature absent: the clear input is deliberately left without a load.
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign sticky_carry      = 1'b0;
    assign sticky_overflow   = 1'b0;
`endif

    // The state register sits in IDLE during reset, so ready is also gated
    // by rst_n to keep upstream from handing over a request it would lose.
    assign req_ready    = rst_n && (state_q == ST_IDLE);
    assign alu_sub_add  = alu_sub_add_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_overflow = rsp_overflow_q;

endmodule

// File: tb/tb_alu32_op_sequencer.sv
// Testbench for alu32_op_sequencer: one instance with SETTLE_CYCLES=1 driving a
// behavioural add/sub ALU, one with SETTLE_CYCLES=4 whose ALU result is driven
// directly so the capture edge can be pinned down. Expected responses are
// queued when a request is issued and popped when the response appears.
module tb_alu32_op_sequencer;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        v;
    } rsp_t;

`ifdef ALU32_STICKY_FLAGS_EN
    localparam logic STICKY_ON = 1'b1;
`else
    localparam logic STICKY_ON = 1'b0;
`endif

    logic clk;
    logic rst1_n, rst4_n;

    // instance 1 (SETTLE_CYCLES = 1)
    logic        r1_valid, r1_ready, r1_sub;
    logic [31:0] r1_a, r1_b;
    logic        a1_sub;
    logic [31:0] a1_a, a1_b, a1_res;
    logic        a1_c, a1_z, a1_v;
    logic        p1_valid, p1_ready;
    logic [31:0] p1_res;
    logic        p1_c, p1_z, p1_v;
    logic        clr1, sc1, so1;

    // instance 4 (SETTLE_CYCLES = 4)
    logic        r4_valid, r4_ready, r4_sub;
    logic [31:0] r4_a, r4_b;
    logic        a4_sub;
    logic [31:0] a4_a, a4_b, a4_res;
    logic        a4_c, a4_z, a4_v;
    logic        p4_valid, p4_ready;
    logic [31:0] p4_res;
    logic        p4_c, p4_z, p4_v;
    logic        clr4, sc4, so4;

    rsp_t sb1[$];
    rsp_t sb4[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    alu32_op_sequencer #(.WIDTH(32), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst1_n),
        .req_valid(r1_valid), .req_ready(r1_ready), .req_sub_add(r1_sub),
        .req_a(r1_a), .req_b(r1_b),
        .alu_sub_add(a1_sub), .alu_a(a1_a), .alu_b(a1_b),
        .alu_result(a1_res), .alu_carry(a1_c), .alu_zero(a1_z), .alu_overflow(a1_v),
        .rsp_valid(p1_valid), .rsp_ready(p1_ready), .rsp_result(p1_res),
        .rsp_carry(p1_c), .rsp_zero(p1_z), .rsp_overflow(p1_v),
        .sticky_clr(clr1), .sticky_carry(sc1), .sticky_overflow(so1)
    );

    alu32_op_sequencer #(.WIDTH(32), .SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst4_n),
        .req_valid(r4_valid), .req_ready(r4_ready), .req_sub_add(r4_sub),
        .req_a(r4_a), .req_b(r4_b),
        .alu_sub_add(a4_sub), .alu_a(a4_a), .alu_b(a4_b),
        .alu_result(a4_res), .alu_carry(a4_c), .alu_zero(a4_z), .alu_overflow(a4_v),
        .rsp_valid(p4_valid), .rsp_ready(p4_ready), .rsp_result(p4_res),
        .rsp_carry(p4_c), .rsp_zero(p4_z), .rsp_overflow(p4_v),
        .sticky_clr(clr4), .sticky_carry(sc4), .sticky_overflow(so4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference add/sub ALU: carry is the carry-out of a + b or a + ~b + 1.
    function automatic rsp_t alu_ref(input logic sub, input logic [31:0] a,
                                     input logic [31:0] b);
        rsp_t        r;
        logic [32:0] s;
        s     = sub ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
        r.res = s[31:0];
        r.c   = s[32];
        r.z   = (s[31:0] == 32'd0);
        r.v   = sub ? ((a[31] != b[31]) && (s[31] != a[31]))
                    : ((a[31] == b[31]) && (s[31] != a[31]));
        return r;
    endfunction

    rsp_t alu1_out;
    always_comb begin
        alu1_out = alu_ref(a1_sub, a1_a, a1_b);
    end
    assign a1_res = alu1_out.res;
    assign a1_c   = alu1_out.c;
    assign a1_z   = alu1_out.z;
    assign a1_v   = alu1_out.v;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check1(input string tag);
        rsp_t e;
        if (sb1.size() == 0) begin
            total_cnt = total_cnt + 1;
            $error("FAIL %s_sb: observed response 0x%08h expected none queued", tag, p1_res);
        end else begin
            e = sb1.pop_front();
            check({tag, "_result"},   p1_res, e.res);
            check({tag, "_carry"},    {31'd0, p1_c}, {31'd0, e.c});
            check({tag, "_zero"},     {31'd0, p1_z}, {31'd0, e.z});
            check({tag, "_overflow"}, {31'd0, p1_v}, {31'd0, e.v});
        end
    endtask

    task automatic sb_check4(input string tag);
        rsp_t e;
        if (sb4.size() == 0) begin
            total_cnt = total_cnt + 1;
            $error("FAIL %s_sb: observed response 0x%08h expected none queued", tag, p4_res);
        end else begin
            e = sb4.pop_front();
            check({tag, "_result"},   p4_res, e.res);
            check({tag, "_carry"},    {31'd0, p4_c}, {31'd0, e.c});
            check({tag, "_zero"},     {31'd0, p4_z}, {31'd0, e.z});
            check({tag, "_overflow"}, {31'd0, p4_v}, {31'd0, e.v});
        end
    endtask

    // One full request/response on instance 1 with rsp_ready held low until
    // the response shows up, then a single-cycle handshake.
    task automatic run_op1(input logic sub, input logic [31:0] a,
                           input logic [31:0] b, input string tag);
        int n;
        r1_sub   = sub;
        r1_a     = a;
        r1_b     = b;
        r1_valid = 1'b1;
        sb1.push_back(alu_ref(sub, a, b));
        tick();
        check({tag, "_alu_a"},   a1_a, a);
        check({tag, "_alu_b"},   b1_of(a1_b), b);
        check({tag, "_alu_sub"}, {31'd0, a1_sub}, {31'd0, sub});
        check({tag, "_busy"},    {31'd0, r1_ready}, 32'd0);
        r1_valid = 1'b0;
        n = 0;
        while (p1_valid !== 1'b1 && n < 20) begin
            tick();
            n = n + 1;
        end
        check({tag, "_latency"}, n, 32'd1);
        sb_check1(tag);
        p1_ready = 1'b1;
        tick();
        p1_ready = 1'b0;
        check({tag, "_rsp_drop"}, {31'd0, p1_valid}, 32'd0);
        check({tag, "_idle"},     {31'd0, r1_ready}, 32'd1);
    endtask

    function automatic logic [31:0] b1_of(input logic [31:0] x);
        return x;
    endfunction

    initial begin
        rst1_n = 1'b0; rst4_n = 1'b0;
        r1_valid = 1'b1; r1_sub = 1'b0; r1_a = 32'h5; r1_b = 32'h3;
        p1_ready = 1'b0; clr1 = 1'b0;
        r4_valid = 1'b1; r4_sub = 1'b0; r4_a = 32'h9; r4_b = 32'h1;
        p4_ready = 1'b0; clr4 = 1'b0;
        a4_res = 32'hAAAAAAAA; a4_c = 1'b0; a4_z = 1'b0; a4_v = 1'b0;

        // 1. reset held with requests pending
        repeat (3) tick();
        check("rst_req_ready",  {31'd0, r1_ready}, 32'd0);
        check("rst_alu_a",      a1_a, 32'd0);
        check("rst_alu_b",      a1_b, 32'd0);
        check("rst_rsp_valid",  {31'd0, p1_valid}, 32'd0);
        check("rst_rsp_result", p1_res, 32'd0);
        check("rst_sticky",     {30'd0, sc1, so1}, 32'd0);
        check("rst4_req_ready", {31'd0, r4_ready}, 32'd0);
        r1_valid = 1'b0; r4_valid = 1'b0;
        rst1_n = 1'b1; rst4_n = 1'b1;
        tick();
        check("rel_req_ready",  {31'd0, r1_ready}, 32'd1);
        check("rel_alu_a",      a1_a, 32'd0);
        check("rel4_req_ready", {31'd0, r4_ready}, 32'd1);

        // 2. add 5 + 3
        run_op1(1'b0, 32'h5, 32'h3, "add");
        check("add_data_kept", p1_res, 32'h8);

        // 3. sub equal operands
        run_op1(1'b1, 32'h12345678, 32'h12345678, "subz");
        check("subz_zero", {31'd0, p1_z}, 32'd1);
        check("subz_res",  p1_res, 32'd0);

        // 4. overflow, response stalled, second request waiting
        r1_sub = 1'b0; r1_a = 32'h7FFFFFFF; r1_b = 32'h1; r1_valid = 1'b1;
        sb1.push_back(alu_ref(1'b0, 32'h7FFFFFFF, 32'h1));
        tick();
        check("ovf_alu_a", a1_a, 32'h7FFFFFFF);
        r1_sub = 1'b1; r1_a = 32'd10; r1_b = 32'd3;
        tick();
        check("ovf_rsp_valid", {31'd0, p1_valid}, 32'd1);
        sb_check1("ovf");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid",     {31'd0, p1_valid}, 32'd1);
            check("stall_result",    p1_res, 32'h80000000);
            check("stall_overflow",  {31'd0, p1_v}, 32'd1);
            check("stall_req_ready", {31'd0, r1_ready}, 32'd0);
            check("stall_alu_a",     a1_a, 32'h7FFFFFFF);
            check("stall_sticky_ov", {31'd0, so1}, {31'd0, STICKY_ON});
        end
        p1_ready = 1'b1;
        sb1.push_back(alu_ref(1'b1, 32'd10, 32'd3));
        tick();
        p1_ready = 1'b0;
        check("ovf_hs_valid",  {31'd0, p1_valid}, 32'd0);
        check("ovf_hs_ready",  {31'd0, r1_ready}, 32'd1);
        check("ovf_hs_alu_a",  a1_a, 32'h7FFFFFFF);
        tick();
        r1_valid = 1'b0;
        check("second_alu_a",   a1_a, 32'd10);
        check("second_alu_sub", {31'd0, a1_sub}, 32'd1);
        tick();
        check("second_valid", {31'd0, p1_valid}, 32'd1);
        sb_check1("second");
        check("second_sticky_ov", {31'd0, so1}, {31'd0, STICKY_ON});
        p1_ready = 1'b1;
        tick();
        p1_ready = 1'b0;
        check("second_drop", {31'd0, p1_valid}, 32'd0);
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        check("clr_sticky_ov", {31'd0, so1}, 32'd0);
        check("clr_sticky_c",  {31'd0, sc1}, 32'd0);

        // 5. four-edge settle window, ALU output changes mid-window
        r4_sub = 1'b0; r4_a = 32'h1; r4_b = 32'h2; r4_valid = 1'b1;
        sb4.push_back(rsp_t'{res: 32'h55555555, c: 1'b0, z: 1'b0, v: 1'b0});
        tick();
        r4_valid = 1'b0;
        check("s4_alu_a",  a4_a, 32'h1);
        check("s4_busy",   {31'd0, r4_ready}, 32'd0);
        tick();
        check("s4_e1_valid", {31'd0, p4_valid}, 32'd0);
        tick();
        check("s4_e2_valid", {31'd0, p4_valid}, 32'd0);
        a4_res = 32'h55555555;
        tick();
        check("s4_e3_valid", {31'd0, p4_valid}, 32'd0);
        tick();
        check("s4_e4_valid", {31'd0, p4_valid}, 32'd1);
        sb_check4("s4");
        p4_ready = 1'b1;
        tick();
        p4_ready = 1'b0;
        check("s4_drop",      {31'd0, p4_valid}, 32'd0);
        check("s4_data_kept", p4_res, 32'h55555555);

        // 6. reset in the middle of the settle window
        a4_res = 32'hAAAAAAAA;
        r4_a = 32'h1234; r4_b = 32'h1; r4_valid = 1'b1;
        tick();
        r4_valid = 1'b0;
        check("abort_alu_a", a4_a, 32'h1234);
        tick();
        tick();
        rst4_n = 1'b0;
        #1;
        check("abort_req_ready", {31'd0, r4_ready}, 32'd0);
        check("abort_alu_a_rst", a4_a, 32'd0);
        check("abort_valid_rst", {31'd0, p4_valid}, 32'd0);
        repeat (2) tick();
        rst4_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_rsp", {31'd0, p4_valid}, 32'd0);
            check("abort_idle",   {31'd0, r4_ready}, 32'd1);
            check("abort_alu_a",  a4_a, 32'd0);
        end
        check("sb_drained", sb1.size() + sb4.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
